// File: rtl/mips_cache_pkg.sv
// Shared types and address helpers for the direct-mapped write-back data cache.
package mips_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_e;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int tag_bits(input int index_bits, input int line_words);
        return 32 - index_bits - off_bits(line_words);
    endfunction

    // Field extractors return right-justified values; callers size-cast to the field width.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits,
                                             input int line_words);
        return addr >> (index_bits + off_bits(line_words));
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_bits,
                                               input int line_words);
        return (addr >> off_bits(line_words)) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int line_words);
        return (addr >> 2) & (32'(line_words) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage for the data cache: one combinational read port,
// one synchronous write port for a data word plus a whole-line metadata update.
module cache_line_array #(
    parameter int INDEX_BITS = 4,
    parameter int LINE_WORDS = 4,
    parameter int TAG_BITS   = 22
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [INDEX_BITS-1:0]         rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
    output logic                          rd_valid,
    output logic                          rd_dirty,
    output logic [TAG_BITS-1:0]           rd_tag,
    output logic [31:0]                   rd_data,
    input  logic                          wr_en,
    input  logic [INDEX_BITS-1:0]         wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
    input  logic [31:0]                   wr_data,
    input  logic                          meta_en,
    input  logic [TAG_BITS-1:0]           meta_tag,
    input  logic                          meta_valid,
    input  logic                          meta_dirty
);
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORD_BITS = $clog2(LINE_WORDS);

    logic [31:0]         data_mem [LINES*LINE_WORDS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

    for (genvar gi = 0; gi < LINES; gi++) begin : g_meta
        assign valid_d[gi] = (meta_en && wr_index == INDEX_BITS'(gi)) ? meta_valid : valid_q[gi];
        assign dirty_d[gi] = (meta_en && wr_index == INDEX_BITS'(gi)) ? meta_dirty : dirty_q[gi];
    end

    // Arrays carry no reset; only the valid/dirty bits need a known state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
        end
        if (meta_en) begin
            tag_mem[wr_index] <= meta_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    logic [WORD_BITS-1:0] unused_word_bits;
    assign unused_word_bits = '0;

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module data_cache_ctrl
    import mips_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        Stall,
    output logic        Mem_req,
    output logic        Mem_we,
    output logic [31:0] Mem_addr,
    output logic [31:0] Mem_wdata,
    input  logic [31:0] Mem_rdata,
    input  logic        Mem_ready,
    output logic [31:0] Hit_count,
    output logic [31:0] Miss_count
);
    localparam int OFF_BITS  = off_bits(LINE_WORDS);
    localparam int TAG_BITS  = tag_bits(INDEX_BITS, LINE_WORDS);
    localparam int WORD_BITS = OFF_BITS - 2;

    cache_state_e         state_q, state_d;
    logic [WORD_BITS-1:0] cnt_q, cnt_d;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [WORD_BITS-1:0]  req_word;
    logic                  req, hit, idle_hit, last_beat;

    logic                  line_valid, line_dirty;
    logic [TAG_BITS-1:0]   line_tag;
    logic [31:0]           line_data;
    logic [WORD_BITS-1:0]  rd_word;

    logic                  wr_en, meta_en, meta_dirty;
    logic [WORD_BITS-1:0]  wr_word;
    logic [31:0]           wr_data;

    assign req_tag   = TAG_BITS'(addr_tag(Address, INDEX_BITS, LINE_WORDS));
    assign req_index = INDEX_BITS'(addr_index(Address, INDEX_BITS, LINE_WORDS));
    assign req_word  = WORD_BITS'(addr_word(Address, LINE_WORDS));

    // Outside IDLE the read port walks the line for write-back beats.
    assign rd_word   = (state_q == IDLE) ? req_word : cnt_q;

    assign req       = MemRead | MemWrite;
    assign hit       = req & line_valid & (line_tag == req_tag);
    assign idle_hit  = (state_q == IDLE) & hit;
    assign last_beat = (cnt_q == '1);
    assign Stall     = req & ~idle_hit;
    assign Read_data = (idle_hit & MemRead) ? line_data : 32'd0;

    cache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk        (CLK),
        .srst       (RESET),
        .rd_index   (req_index),
        .rd_word    (rd_word),
        .rd_valid   (line_valid),
        .rd_dirty   (line_dirty),
        .rd_tag     (line_tag),
        .rd_data    (line_data),
        .wr_en      (wr_en),
        .wr_index   (req_index),
        .wr_word    (wr_word),
        .wr_data    (wr_data),
        .meta_en    (meta_en),
        .meta_tag   (req_tag),
        .meta_valid (1'b1),
        .meta_dirty (meta_dirty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        Mem_req    = 1'b0;
        Mem_we     = 1'b0;
        Mem_addr   = 32'd0;
        Mem_wdata  = 32'd0;
        wr_en      = 1'b0;
        wr_word    = req_word;
        wr_data    = Write_data;
        meta_en    = 1'b0;
        meta_dirty = 1'b1;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    // Store hit rewrites the current tag and marks the line dirty.
                    wr_en   = MemWrite;
                    meta_en = MemWrite;
                end else if (req) begin
                    cnt_d   = '0;
                    state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                Mem_req   = 1'b1;
                Mem_we    = 1'b1;
                Mem_addr  = {line_tag, req_index, cnt_q, 2'b00};
                Mem_wdata = line_data;
                if (Mem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                Mem_req  = 1'b1;
                Mem_addr = {req_tag, req_index, cnt_q, 2'b00};
                if (Mem_ready) begin
                    wr_en   = 1'b1;
                    wr_word = cnt_q;
                    wr_data = Mem_rdata;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_beat) begin
                        meta_en    = 1'b1;
                        meta_dirty = 1'b0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        miss_start;

    assign miss_start = (state_q == IDLE) & req & ~hit;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (idle_hit && hit_count_q != 32'hFFFF_FFFF) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_start && miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign Hit_count  = hit_count_q;
    assign Miss_count = miss_count_q;
`else
    assign Hit_count  = 32'd0;
    assign Miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: hit vectors from a table, miss bursts
// checked beat-by-beat against a queue of expected backing-memory transactions.
module tb_data_cache_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Address, Write_data;
    logic        MemRead, MemWrite;
    logic [31:0] Read_data;
    logic        Stall, Mem_req, Mem_we;
    logic [31:0] Mem_addr, Mem_wdata, Mem_rdata;
    logic        Mem_ready;
    logic [31:0] Hit_count, Miss_count;

    logic        ready_en;
    logic [31:0] mem [1024];

    int n_vec = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic        exp_stall;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[9];

    always #5 CLK = ~CLK;

    data_cache_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .Stall      (Stall),
        .Mem_req    (Mem_req),
        .Mem_we     (Mem_we),
        .Mem_addr   (Mem_addr),
        .Mem_wdata  (Mem_wdata),
        .Mem_rdata  (Mem_rdata),
        .Mem_ready  (Mem_ready),
        .Hit_count  (Hit_count),
        .Miss_count (Miss_count)
    );

    // Backing-memory responder: garbage on the data bus whenever it is not ready.
    assign Mem_ready = ready_en;
    assign Mem_rdata = ready_en ? mem[Mem_addr[11:2]] : 32'hBAD0_BAD0;

    always @(posedge CLK) begin
        if (!RESET && Mem_req && Mem_ready && Mem_we) mem[Mem_addr[11:2]] <= Mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && Mem_req && Mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_addr", Mem_addr, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_we", {31'd0, Mem_we}, {31'd0, e.we});
                check("beat_addr", Mem_addr, e.addr);
                if (e.we) check("beat_wdata", Mem_wdata, e.wdata);
            end
        end
    end

    task automatic push_reads(input logic [31:0] base);
        for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, base + 32'(4 * k), 32'd0});
    endtask

    // Presents a request that must miss, counts stalled cycles, then checks the hit result.
    task automatic access_miss(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [31:0] wdata, input int exp_cycles,
                               input logic [31:0] exp_rd);
        int cycles;
        @(posedge CLK); #1;
        Address = addr; MemRead = rd; MemWrite = wr; Write_data = wdata;
        @(negedge CLK);
        check("miss_stall", {31'd0, Stall}, 32'd1);
        cycles = 1;
        while (Stall && cycles < 64) begin
            @(negedge CLK);
            if (Stall) cycles++;
        end
        check("miss_cycles", cycles, exp_cycles);
        check("refill_rdata", Read_data, exp_rd);
        exp_miss++;
        exp_hits++;
        @(posedge CLK); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        check({tag, "_hit_count"}, Hit_count, exp_hits);
        check({tag, "_miss_count"}, Miss_count, exp_miss);
`else
        check({tag, "_hit_count"}, Hit_count, 32'd0);
        check({tag, "_miss_count"}, Miss_count, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[10'h10] = 32'h11; mem[10'h11] = 32'h22; mem[10'h12] = 32'h33; mem[10'h13] = 32'h44;
        mem[10'h50] = 32'h55; mem[10'h51] = 32'h66; mem[10'h52] = 32'h77; mem[10'h53] = 32'h88;
        mem[10'h90] = 32'hA0; mem[10'h91] = 32'hA1; mem[10'h92] = 32'hA2; mem[10'h93] = 32'hA3;

        //            addr           wdata          rd    wr    stall rdata
        vecs[0] = '{32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_0044, 32'h0,         1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{32'h0000_0044, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{32'h0000_0040, 32'h0,         1'b1, 1'b0, 1'b0, 32'h11};
        vecs[4] = '{32'h0000_004E, 32'h0,         1'b1, 1'b0, 1'b0, 32'h44};
        vecs[5] = '{32'h0000_0048, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0, 32'h33};
        vecs[6] = '{32'h0000_0048, 32'h0,         1'b1, 1'b0, 1'b0, 32'hCAFE_0001};
        vecs[7] = '{32'h0000_0048, 32'h33,        1'b0, 1'b1, 1'b0, 32'h0};
        vecs[8] = '{32'h0000_0048, 32'h0,         1'b1, 1'b0, 1'b0, 32'h33};

        RESET = 1'b1; Address = 32'd0; Write_data = 32'd0;
        MemRead = 1'b0; MemWrite = 1'b0; ready_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset_stall", {31'd0, Stall}, 32'd0);
        check("reset_mem_req", {31'd0, Mem_req}, 32'd0);
        check("reset_mem_we", {31'd0, Mem_we}, 32'd0);
        check("reset_rdata", Read_data, 32'd0);
        check_stats("reset");

        // Cold miss on a clean, invalid line: four refill beats then a hit.
        push_reads(32'h40);
        access_miss(32'h40, 1'b1, 1'b0, 32'd0, 5, 32'h11);

        for (int i = 0; i < 9; i++) begin
            @(posedge CLK); #1;
            Address = vecs[i].addr; Write_data = vecs[i].wdata;
            MemRead = vecs[i].rd; MemWrite = vecs[i].wr;
            @(negedge CLK);
            check($sformatf("vec%0d_stall", i), {31'd0, Stall}, {31'd0, vecs[i].exp_stall});
            check($sformatf("vec%0d_rdata", i), Read_data, vecs[i].exp_rdata);
            check($sformatf("vec%0d_mem_req", i), {31'd0, Mem_req}, 32'd0);
            if (vecs[i].rd || vecs[i].wr) exp_hits++;
        end
        @(posedge CLK); #1;
        MemRead = 1'b0; MemWrite = 1'b0;

        // Conflict miss on a dirty line: write-back of the old contents, then refill.
        exp_q.push_back('{1'b1, 32'h40, 32'h11});
        exp_q.push_back('{1'b1, 32'h44, 32'hDEAD_BEEF});
        exp_q.push_back('{1'b1, 32'h48, 32'h33});
        exp_q.push_back('{1'b1, 32'h4C, 32'h44});
        push_reads(32'h140);
        access_miss(32'h140, 1'b1, 1'b0, 32'd0, 9, 32'h55);
        check("wb_mem_word1", mem[10'h11], 32'hDEAD_BEEF);
        check_stats("after_conflict");

        // Refill with the memory stalling for five cycles after the first beat.
        push_reads(32'h240);
        @(posedge CLK); #1;
        Address = 32'h240; MemRead = 1'b1;
        @(negedge CLK);
        check("slow_miss_stall", {31'd0, Stall}, 32'd1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        ready_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("hold_addr", Mem_addr, 32'h244);
            check("hold_stall", {31'd0, Stall}, 32'd1);
            @(posedge CLK); #1;
        end
        ready_en = 1'b1;
        k = 0;
        @(negedge CLK);
        while (Stall && k < 20) begin
            k++;
            @(negedge CLK);
        end
        check("slow_refill_done", {31'd0, Stall}, 32'd0);
        check("slow_refill_rdata", Read_data, 32'hA0);
        @(posedge CLK); #1;
        Address = 32'h244;
        @(negedge CLK);
        check("slow_refill_word1", Read_data, 32'hA1);
        @(posedge CLK); #1;
        MemRead = 1'b0;

        // Reset in the middle of a refill burst abandons it and invalidates every line.
        exp_q.push_back('{1'b0, 32'h380, 32'd0});
        @(posedge CLK); #1;
        Address = 32'h380; MemRead = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; MemRead = 1'b0;
        @(negedge CLK);
        check("post_reset_mem_req", {31'd0, Mem_req}, 32'd0);
        check("post_reset_stall", {31'd0, Stall}, 32'd0);
        check("post_reset_queue", exp_q.size(), 32'd0);
        exp_hits = 0;
        exp_miss = 0;
        check_stats("post_reset");
        push_reads(32'h240);
        access_miss(32'h240, 1'b1, 1'b0, 32'd0, 5, 32'hA0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
